muldiv_iterative: RTL

- Multi-cycle RV32M execute unit that sits beside ALU_nbit in the EX stage and is fed from the same ID/EX operand and alu_control path.
- Replaces the single-cycle `*`, `/` and `%` paths with a shared shift-add multiplier and a restoring divider.
- Its result is muxed into the EX result path ahead of EX/MEM.
- `busy` drives the hazard unit to stall IF/ID/EX while an operation runs.

---
 rtl/muldiv_iterative_pkg.sv | 29 ++
 rtl/muldiv_signfix.sv | 12 +
 rtl/muldiv_iterative.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/muldiv_iterative_pkg.sv
// rtl/muldiv_iterative_pkg.sv - opcode encodings, FSM states and op classifiers for muldiv_iterative
package muldiv_iterative_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  function automatic logic is_mul_op(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_md_op(input logic [4:0] op);
    return is_mul_op(op) || (op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate, used for magnitudes and final sign fix
module muldiv_signfix #(
  parameter int w = 32
) (
  input  logic [w-1:0] value,
  input  logic         negate,
  output logic [w-1:0] out
);

  assign out = negate ? -value : value;

endmodule

// File: rtl/muldiv_iterative.sv
// rtl/muldiv_iterative.sv - iterative RV32M unit: shift-add multiplier and restoring divider sharing one accumulator
module muldiv_iterative
  import muldiv_iterative_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   alu_control,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);

  localparam int cw = $clog2(n);

  md_state_t      state_q, state_d;
  logic [4:0]     op_q;
  logic [n-1:0]   b_mag_q, acc_hi, acc_lo;
  logic [cw-1:0]  cnt;
  logic           neg_q, rem_neg_q, raw_q;

  logic           accept, a_signed, b_signed, a_neg, b_neg;
  logic           div_zero, div_ovf, special;
  logic [n-1:0]   a_mag, b_mag, special_val;
  logic [n:0]     mul_sum, div_shift, div_diff;
  logic [2*n-1:0] prod_signed;
  logic [n-1:0]   quo_signed, rem_signed, fix_val;

  assign accept   = (state_q == MD_IDLE) && start && is_md_op(alu_control);
  assign a_signed = alu_control inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign b_signed = alu_control inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  assign a_neg    = a_signed & A[n-1];
  assign b_neg    = b_signed & B[n-1];

  muldiv_signfix #(.w(n)) u_a_abs (.value(A), .negate(a_neg), .out(a_mag));
  muldiv_signfix #(.w(n)) u_b_abs (.value(B), .negate(b_neg), .out(b_mag));

  // Divide-by-zero and INT_MIN / -1 skip the iteration and go straight to FIX.
  assign div_zero = !is_mul_op(alu_control) && (B == '0);
  assign div_ovf  = (alu_control inside {ALU_DIV, ALU_REM}) &&
                    (A == {1'b1, {(n-1){1'b0}}}) && (B == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = (alu_control inside {ALU_DIV, ALU_DIVU}) ? '1 : A;
    else if (alu_control == ALU_DIV)
      special_val = A;
  end

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? b_mag_q : '0)};
  assign div_shift = {acc_hi, acc_lo[n-1]};
  assign div_diff  = div_shift - {1'b0, b_mag_q};

  muldiv_signfix #(.w(2*n)) u_prod_fix (.value({acc_hi, acc_lo}), .negate(neg_q), .out(prod_signed));
  muldiv_signfix #(.w(n))   u_quo_fix  (.value(acc_lo), .negate(neg_q), .out(quo_signed));
  muldiv_signfix #(.w(n))   u_rem_fix  (.value(acc_hi), .negate(rem_neg_q), .out(rem_signed));

  always_comb begin
    fix_val = rem_signed;
    if (raw_q)
      fix_val = acc_lo;
    else begin
      case (op_q)
        ALU_MUL:                        fix_val = prod_signed[n-1:0];
        ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_val = prod_signed[2*n-1:n];
        ALU_DIV, ALU_DIVU:              fix_val = quo_signed;
        default:                        fix_val = rem_signed;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = special ? MD_FIX : MD_CALC;
      MD_CALC: begin
        if (flush)           state_d = MD_IDLE;
        else if (cnt == '0)  state_d = MD_FIX;
      end
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = (state_q != MD_IDLE);

  // acc_hi holds the partial product or remainder; acc_lo the multiplier or dividend/quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      b_mag_q   <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      raw_q     <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            op_q      <= alu_control;
            b_mag_q   <= b_mag;
            cnt       <= cw'(n - 1);
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            raw_q     <= special;
            acc_hi    <= '0;
            acc_lo    <= special ? special_val : a_mag;
          end
        end
        MD_CALC: begin
          if (!flush) begin
            cnt <= cnt - cw'(1);
            if (is_mul_op(op_q)) begin
              acc_hi <= mul_sum[n:1];
              acc_lo <= {mul_sum[0], acc_lo[n-1:1]};
            end else if (!div_diff[n]) begin
              acc_hi <= div_diff[n-1:0];
              acc_lo <= {acc_lo[n-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[n-1:0];
              acc_lo <= {acc_lo[n-2:0], 1'b0};
            end
          end
        end
        MD_FIX: begin
          if (!flush) begin
            result <= fix_val;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
